// File: rtl/ysyx_210238_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, access size codes,
// byte-strobe base masks and the natural-alignment helper.
package ysyx_210238_lsu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned STRB_W = 8;
    localparam int unsigned OFF_W  = 3;
    localparam int unsigned RD_AW  = 5;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_W = 2'd2;
    localparam logic [SIZE_W-1:0] SZ_D = 2'd3;

    localparam logic [STRB_W-1:0] STRB_MASK_B = 8'h01;
    localparam logic [STRB_W-1:0] STRB_MASK_H = 8'h03;
    localparam logic [STRB_W-1:0] STRB_MASK_W = 8'h0F;
    localparam logic [STRB_W-1:0] STRB_MASK_D = 8'hFF;

    // Byte-enable pattern of an access of the given size starting at lane 0.
    function automatic logic [STRB_W-1:0] size_mask(input logic [SIZE_W-1:0] size);
        logic [STRB_W-1:0] m;
        case (size)
            SZ_B:    m = STRB_MASK_B;
            SZ_H:    m = STRB_MASK_H;
            SZ_W:    m = STRB_MASK_W;
            default: m = STRB_MASK_D;
        endcase
        return m;
    endfunction

    // True when the byte offset is not a multiple of the access size.
    function automatic logic misaligned(input logic [SIZE_W-1:0] size,
                                        input logic [OFF_W-1:0]  off);
        logic r;
        case (size)
            SZ_B:    r = 1'b0;
            SZ_H:    r = off[0];
            SZ_W:    r = |off[1:0];
            default: r = |off;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ysyx_210238_lsu_ldext.sv
// Load data extraction: shifts the addressed bytes of a bus beat down to
// lane 0, truncates to the access size and sign/zero-extends to 64 bits.
module ysyx_210238_lsu_ldext
    import ysyx_210238_lsu_pkg::*;
(
    input  logic [XLEN-1:0]   rdata,
    input  logic [OFF_W-1:0]  offset,
    input  logic [SIZE_W-1:0] size,
    input  logic              is_unsigned,
    output logic [XLEN-1:0]   data_c
);

    logic [XLEN-1:0] shifted;
    logic            sign;

    // Align, truncate and extend the selected bytes.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        sign    = 1'b0;
        data_c  = shifted;
        case (size)
            SZ_B: begin
                sign   = ~is_unsigned & shifted[7];
                data_c = {{56{sign}}, shifted[7:0]};
            end
            SZ_H: begin
                sign   = ~is_unsigned & shifted[15];
                data_c = {{48{sign}}, shifted[15:0]};
            end
            SZ_W: begin
                sign   = ~is_unsigned & shifted[31];
                data_c = {{32{sign}}, shifted[31:0]};
            end
            default: data_c = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_210238_lsu.sv
// Load/store unit between EX and WB. Accepts one operation at a time,
// issues at most one aligned bus beat and presents a one-cycle WB result.
// Optional feature: define YSYX_210238_LSU_MISALIGN_CHK_EN to add o_misalign
// and short-circuit accesses that are not naturally aligned.
module ysyx_210238_lsu
    import ysyx_210238_lsu_pkg::*;
#(
    parameter int unsigned AW = 64
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_unsigned,
    input  logic [SIZE_W-1:0] i_size,
    input  logic [AW-1:0]     i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [XLEN-1:0]   i_rd_data,
    input  logic [RD_AW-1:0]  i_rd_addr,
    input  logic              i_rd_wen,
    output logic              o_req_valid,
    input  logic              i_req_ready,
    output logic [AW-1:0]     o_req_addr,
    output logic              o_req_wen,
    output logic [XLEN-1:0]   o_req_wdata,
    output logic [STRB_W-1:0] o_req_wstrb,
    input  logic              i_resp_valid,
    input  logic [XLEN-1:0]   i_resp_rdata,
    output logic              o_wb_valid,
    output logic              o_rd_wen,
    output logic [RD_AW-1:0]  o_rd_addr,
    output logic [XLEN-1:0]   o_rd_data,
    output logic              o_mem_read,
`ifdef YSYX_210238_LSU_MISALIGN_CHK_EN
    output logic              o_misalign,
`endif
    output logic [XLEN-1:0]   o_mem_rdata
);

    lsu_state_e        state;

    logic [OFF_W-1:0]  lat_off;
    logic [SIZE_W-1:0] lat_size;
    logic              lat_uns;
    logic              lat_load;
    logic [RD_AW-1:0]  lat_rd_addr;
    logic              lat_rd_wen;
    logic [XLEN-1:0]   lat_rd_data;

    logic              acc_mem;
    logic              acc_store;
    logic              acc_mis;
    logic [OFF_W-1:0]  acc_off;
    logic [STRB_W-1:0] acc_strb;
    logic [XLEN-1:0]   acc_wdata;
    logic [XLEN-1:0]   ld_data_c;

    // Decode of the incoming operation; a read+write request counts as a load.
    always_comb begin
        acc_off   = i_addr[OFF_W-1:0];
        acc_mem   = i_mem_read | i_mem_write;
        acc_store = i_mem_write & ~i_mem_read;
        acc_strb  = acc_store ? STRB_W'(size_mask(i_size) << acc_off) : '0;
        acc_wdata = acc_store ? (i_wdata << {acc_off, 3'b000}) : '0;
`ifdef YSYX_210238_LSU_MISALIGN_CHK_EN
        acc_mis   = acc_mem & misaligned(i_size, acc_off);
`else
        acc_mis   = 1'b0;
`endif
    end

    ysyx_210238_lsu_ldext u_ldext (
        .rdata       (i_resp_rdata),
        .offset      (lat_off),
        .size        (lat_size),
        .is_unsigned (lat_uns),
        .data_c      (ld_data_c)
    );

    // Operation sequencer with registered handshake, bus and WB outputs.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            o_ready     <= 1'b1;
            o_req_valid <= 1'b0;
            o_req_addr  <= '0;
            o_req_wen   <= 1'b0;
            o_req_wdata <= '0;
            o_req_wstrb <= '0;
            o_wb_valid  <= 1'b0;
            o_rd_wen    <= 1'b0;
            o_rd_addr   <= '0;
            o_rd_data   <= '0;
            o_mem_read  <= 1'b0;
            o_mem_rdata <= '0;
`ifdef YSYX_210238_LSU_MISALIGN_CHK_EN
            o_misalign  <= 1'b0;
`endif
            lat_off     <= '0;
            lat_size    <= '0;
            lat_uns     <= 1'b0;
            lat_load    <= 1'b0;
            lat_rd_addr <= '0;
            lat_rd_wen  <= 1'b0;
            lat_rd_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        o_ready <= 1'b0;
                        if (acc_mem && !acc_mis) begin
                            lat_off     <= acc_off;
                            lat_size    <= i_size;
                            lat_uns     <= i_unsigned;
                            lat_load    <= i_mem_read;
                            lat_rd_addr <= i_rd_addr;
                            lat_rd_wen  <= i_rd_wen;
                            lat_rd_data <= i_rd_data;
                            o_req_valid <= 1'b1;
                            o_req_addr  <= {i_addr[AW-1:OFF_W], OFF_W'(0)};
                            o_req_wen   <= acc_store;
                            o_req_wdata <= acc_wdata;
                            o_req_wstrb <= acc_strb;
                            state       <= ST_REQ;
                        end else begin
                            o_wb_valid  <= 1'b1;
                            o_rd_addr   <= i_rd_addr;
                            o_rd_data   <= i_rd_data;
                            o_rd_wen    <= i_rd_wen & ~acc_mem;
                            o_mem_read  <= i_mem_read;
                            o_mem_rdata <= '0;
`ifdef YSYX_210238_LSU_MISALIGN_CHK_EN
                            o_misalign  <= acc_mis;
`endif
                            state       <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    if (i_req_ready) begin
                        o_req_valid <= 1'b0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_resp_valid) begin
                        o_wb_valid  <= 1'b1;
                        o_rd_addr   <= lat_rd_addr;
                        o_rd_data   <= lat_rd_data;
                        o_rd_wen    <= lat_rd_wen & lat_load;
                        o_mem_read  <= lat_load;
                        o_mem_rdata <= lat_load ? ld_data_c : '0;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_wb_valid <= 1'b0;
                    o_rd_wen   <= 1'b0;
`ifdef YSYX_210238_LSU_MISALIGN_CHK_EN
                    o_misalign <= 1'b0;
`endif
                    o_ready    <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_210238_lsu.sv
// Self-checking bench for ysyx_210238_lsu: directed vector table, reset
// corner sequences and randomized operations against a byte-lane model.
module tb_ysyx_210238_lsu;

    logic        clock;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_mem_read;
    logic        i_mem_write;
    logic        i_unsigned;
    logic [1:0]  i_size;
    logic [63:0] i_addr;
    logic [63:0] i_wdata;
    logic [63:0] i_rd_data;
    logic [4:0]  i_rd_addr;
    logic        i_rd_wen;
    logic        o_req_valid;
    logic        i_req_ready;
    logic [63:0] o_req_addr;
    logic        o_req_wen;
    logic [63:0] o_req_wdata;
    logic [7:0]  o_req_wstrb;
    logic        i_resp_valid;
    logic [63:0] i_resp_rdata;
    logic        o_wb_valid;
    logic        o_rd_wen;
    logic [4:0]  o_rd_addr;
    logic [63:0] o_rd_data;
    logic        o_mem_read;
    logic [63:0] o_mem_rdata;
`ifdef YSYX_210238_LSU_MISALIGN_CHK_EN
    logic        o_misalign;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_210238_lsu #(.AW(64)) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_unsigned   (i_unsigned),
        .i_size       (i_size),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_rd_data    (i_rd_data),
        .i_rd_addr    (i_rd_addr),
        .i_rd_wen     (i_rd_wen),
        .o_req_valid  (o_req_valid),
        .i_req_ready  (i_req_ready),
        .o_req_addr   (o_req_addr),
        .o_req_wen    (o_req_wen),
        .o_req_wdata  (o_req_wdata),
        .o_req_wstrb  (o_req_wstrb),
        .i_resp_valid (i_resp_valid),
        .i_resp_rdata (i_resp_rdata),
        .o_wb_valid   (o_wb_valid),
        .o_rd_wen     (o_rd_wen),
        .o_rd_addr    (o_rd_addr),
        .o_rd_data    (o_rd_data),
        .o_mem_read   (o_mem_read),
`ifdef YSYX_210238_LSU_MISALIGN_CHK_EN
        .o_misalign   (o_misalign),
`endif
        .o_mem_rdata  (o_mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic        uns;
        logic [1:0]  size;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd_addr;
        logic        rd_wen;
        logic [63:0] rd_data;
        logic [63:0] rdata;
        int          stall;
        int          dly;
        logic        early;
        logic [63:0] e_rdata;
        logic [7:0]  e_strb;
        logic [63:0] e_wdata;
        logic        mis;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte lanes covered by an access of 2**size bytes at off.
    function automatic logic [7:0] m_strb(input logic [1:0] size, input int off);
        logic [7:0] s;
        int n;
        n = 1 << size;
        s = '0;
        for (int b = 0; b < 8; b++) s[b] = (b >= off) && (b < off + n);
        return s;
    endfunction

    // Reference model: store data placed starting at byte lane off.
    function automatic logic [63:0] m_wdata(input logic [63:0] wd, input int off);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 8; b++)
            if (b >= off) r[8*b +: 8] = wd[8*(b-off) +: 8];
        return r;
    endfunction

    // Reference model: pick 2**size bytes from lane off, then extend.
    function automatic logic [63:0] m_load(input logic [63:0] rd, input int off,
                                           input logic [1:0] size, input logic uns);
        logic [63:0] r;
        int n;
        n = 1 << size;
        r = '0;
        for (int k = 0; k < n; k++)
            if (off + k < 8) r[8*k +: 8] = rd[8*(off+k) +: 8];
        if (!uns && size != 2'd3 && r[8*n-1])
            for (int k = n; k < 8; k++) r[8*k +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic drive_idle();
        i_valid      = 1'b0;
        i_mem_read   = 1'b0;
        i_mem_write  = 1'b0;
        i_unsigned   = 1'b0;
        i_size       = 2'd0;
        i_addr       = '0;
        i_wdata      = '0;
        i_rd_data    = '0;
        i_rd_addr    = '0;
        i_rd_wen     = 1'b0;
        i_req_ready  = 1'b0;
        i_resp_valid = 1'b0;
        i_resp_rdata = '0;
    endtask

    // Run one operation end to end, acting as the bus and checking each phase.
    task automatic do_op(input vec_t v);
        logic is_mem;
        logic is_load;
        is_mem  = v.rd | v.wr;
        is_load = v.rd;
        @(negedge clock);
        chk("ready_idle", o_ready, 1'b1);
        i_valid     = 1'b1;
        i_mem_read  = v.rd;
        i_mem_write = v.wr;
        i_unsigned  = v.uns;
        i_size      = v.size;
        i_addr      = v.addr;
        i_wdata     = v.wdata;
        i_rd_addr   = v.rd_addr;
        i_rd_wen    = v.rd_wen;
        i_rd_data   = v.rd_data;
        @(negedge clock);
        i_valid = 1'b0;
        chk("ready_busy", o_ready, 1'b0);
        if (is_mem && !v.mis) begin
            for (int s = 0; s <= v.stall; s++) begin
                chk("req_valid", o_req_valid, 1'b1);
                chk("req_addr", o_req_addr, v.addr & ~64'h7);
                chk("req_wen", o_req_wen, v.wr & ~v.rd);
                if (!is_load) begin
                    chk("req_wstrb", o_req_wstrb, v.e_strb);
                    chk("req_wdata", o_req_wdata, v.e_wdata);
                end
                chk("wb_in_req", o_wb_valid, 1'b0);
                if (s == v.stall) begin
                    i_req_ready = 1'b1;
                    if (v.early) begin
                        i_resp_valid = 1'b1;
                        i_resp_rdata = ~v.rdata;
                    end
                end
                @(negedge clock);
            end
            i_req_ready  = 1'b0;
            i_resp_valid = 1'b0;
            chk("req_drop", o_req_valid, 1'b0);
            chk("wb_in_wait", o_wb_valid, 1'b0);
            repeat (v.dly) @(negedge clock);
            i_resp_valid = 1'b1;
            i_resp_rdata = v.rdata;
            @(negedge clock);
            i_resp_valid = 1'b0;
        end else begin
            chk("no_req", o_req_valid, 1'b0);
        end
        chk("wb_valid", o_wb_valid, 1'b1);
        chk("rd_addr", o_rd_addr, v.rd_addr);
        chk("rd_wen", o_rd_wen, v.rd_wen & (is_load | ~is_mem) & ~v.mis);
        chk("mem_read", o_mem_read, v.rd);
        if (!is_mem) chk("rd_data", o_rd_data, v.rd_data);
        if (is_load && !v.mis) chk("mem_rdata", o_mem_rdata, v.e_rdata);
`ifdef YSYX_210238_LSU_MISALIGN_CHK_EN
        chk("misalign", o_misalign, v.mis);
`endif
        @(negedge clock);
        chk("wb_pulse_end", o_wb_valid, 1'b0);
        chk("rd_wen_gated", o_rd_wen, 1'b0);
        chk("ready_back", o_ready, 1'b1);
    endtask

    vec_t vecs[12];

    initial begin
        drive_idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_req_valid", o_req_valid, 1'b0);
        chk("rst_wb_valid", o_wb_valid, 1'b0);
        chk("rst_rd_wen", o_rd_wen, 1'b0);
        chk("rst_rd_data", o_rd_data, 64'h0);
        chk("rst_mem_rdata", o_mem_rdata, 64'h0);
        repeat (3) @(negedge clock);
        rst_n = 1'b1;

        // rd, wr, uns, size, addr, wdata, rd_addr, rd_wen, rd_data, rdata,
        // stall, dly, early, e_rdata, e_strb, e_wdata, mis
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0, 5'd5, 1'b1, 64'h1234, 64'h0,
                     0, 0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 64'h8000_0003, 64'h0, 5'd7, 1'b1, 64'h0,
                     64'h0000_0000_8000_0000, 0, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'd0, 64'h8000_0003, 64'h0, 5'd8, 1'b1, 64'h0,
                     64'h0000_0000_8000_0000, 1, 0, 1'b0, 64'h80, 8'h00, 64'h0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'd1, 64'h8000_0006, 64'hBEEF, 5'd9, 1'b1, 64'h55,
                     64'h0, 5, 2, 1'b0, 64'h0, 8'hC0, 64'hBEEF_0000_0000_0000, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'd3, 64'h8000_0010, 64'h0, 5'd10, 1'b1, 64'h0,
                     64'h8123_4567_89AB_CDEF, 0, 0, 1'b0, 64'h8123_4567_89AB_CDEF, 8'h00, 64'h0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'd2, 64'h8000_0004, 64'h0, 5'd11, 1'b1, 64'h0,
                     64'h8765_4321_0000_0000, 2, 0, 1'b1, 64'hFFFF_FFFF_8765_4321, 8'h00, 64'h0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 2'd1, 64'h8000_0002, 64'h0, 5'd12, 1'b1, 64'h0,
                     64'h0000_0000_F00D_0000, 0, 3, 1'b0, 64'hF00D, 8'h00, 64'h0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 2'd1, 64'h8000_0002, 64'h0, 5'd12, 1'b1, 64'h0,
                     64'h0000_0000_F00D_0000, 0, 0, 1'b0, 64'hFFFF_FFFF_FFFF_F00D, 8'h00, 64'h0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'd3, 64'h8000_0008, 64'hDEAD, 5'd13, 1'b1, 64'h0,
                     64'h1122_3344_5566_7788, 1, 1, 1'b0, 64'h1122_3344_5566_7788, 8'h00, 64'h0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 64'h8000_0007, 64'hAB, 5'd14, 1'b1, 64'h0,
                     64'h0, 0, 0, 1'b1, 64'h0, 8'h80, 64'hAB00_0000_0000_0000, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 2'd2, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF, 5'd15, 1'b1, 64'h0,
                     64'h0, 3, 1, 1'b0, 64'h0, 8'h0F, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0, 5'd31, 1'b0, 64'hCAFE_F00D_0000_0001,
                     64'h0, 0, 0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0};

        for (int i = 0; i < 12; i++) do_op(vecs[i]);

`ifdef YSYX_210238_LSU_MISALIGN_CHK_EN
        begin
            vec_t mv;
            mv = '{1'b1, 1'b0, 1'b0, 2'd2, 64'h8000_0002, 64'h0, 5'd3, 1'b1, 64'h0,
                   64'h0, 0, 0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1};
            do_op(mv);
        end
`endif

        // Reset while the request is outstanding.
        @(negedge clock);
        i_valid = 1'b1; i_mem_read = 1'b1; i_size = 2'd3; i_addr = 64'h8000_0020;
        i_rd_addr = 5'd4; i_rd_wen = 1'b1;
        @(negedge clock);
        drive_idle();
        chk("rreq_valid_before", o_req_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rreq_valid_async", o_req_valid, 1'b0);
        chk("rreq_ready_async", o_ready, 1'b1);
        chk("rreq_wb", o_wb_valid, 1'b0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        chk("rreq_idle_wb", o_wb_valid, 1'b0);
        chk("rreq_idle_req", o_req_valid, 1'b0);

        // Reset while waiting for the response; a late response is ignored.
        @(negedge clock);
        i_valid = 1'b1; i_mem_read = 1'b1; i_size = 2'd2; i_addr = 64'h8000_0040;
        i_rd_addr = 5'd6; i_rd_wen = 1'b1;
        @(negedge clock);
        drive_idle();
        i_req_ready = 1'b1;
        @(negedge clock);
        i_req_ready = 1'b0;
        chk("rwait_in_wait", o_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rwait_req_valid", o_req_valid, 1'b0);
        chk("rwait_wb", o_wb_valid, 1'b0);
        chk("rwait_ready", o_ready, 1'b1);
        @(negedge clock);
        rst_n = 1'b1;
        i_resp_valid = 1'b1;
        i_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clock);
        i_resp_valid = 1'b0;
        chk("rwait_late_wb", o_wb_valid, 1'b0);
        chk("rwait_late_rdwen", o_rd_wen, 1'b0);
        @(negedge clock);
        chk("rwait_late_wb2", o_wb_valid, 1'b0);
        chk("rwait_late_ready", o_ready, 1'b1);

        // Randomized operations against the byte-lane model.
        for (int n = 0; n < 250; n++) begin
            vec_t v;
            int   kind;
            int   off;
            kind      = $urandom_range(0, 3);
            v.rd      = (kind == 1) || (kind == 3);
            v.wr      = (kind == 2) || (kind == 3);
            v.uns     = 1'($urandom_range(0, 1));
            v.size    = 2'($urandom_range(0, 3));
            v.addr    = {32'h0, 32'h8000_0000 | 32'($urandom_range(0, 4095))};
            v.wdata   = {$urandom, $urandom};
            v.rd_addr = 5'($urandom_range(0, 31));
            v.rd_wen  = 1'($urandom_range(0, 1));
            v.rd_data = {$urandom, $urandom};
            v.rdata   = {$urandom, $urandom};
            v.stall   = $urandom_range(0, 3);
            v.dly     = $urandom_range(0, 3);
            v.early   = 1'($urandom_range(0, 1));
            off       = int'(v.addr[2:0]);
            v.e_rdata = m_load(v.rdata, off, v.size, v.uns);
            v.e_strb  = m_strb(v.size, off);
            v.e_wdata = m_wdata(v.wdata, off);
`ifdef YSYX_210238_LSU_MISALIGN_CHK_EN
            v.mis     = (v.rd | v.wr) && ((off % (1 << v.size)) != 0);
`else
            v.mis     = 1'b0;
`endif
            do_op(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_210238_lsu.md
YSYX_210238_LSU -- requirements
Module: ysyx_210238_lsu

Interface
REQ-001 SHALL have parameter AW, default 64, data-bus address width; only 64 is required.
REQ-002 SHALL have port clock  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports i_valid in 1, o_ready out 1: EX->LSU handshake, transfer when both high.
REQ-005 SHALL have ports i_mem_read in 1, i_mem_write in 1, i_unsigned in 1, i_size in 2 (0=B,1=H,2=W,3=D).
REQ-006 SHALL have ports i_addr in AW, i_wdata in 64, i_rd_data in 64, i_rd_addr in 5, i_rd_wen in 1.
REQ-007 SHALL have bus request ports o_req_valid out 1, i_req_ready in 1, o_req_addr out AW (8-byte aligned), o_req_wen out 1, o_req_wdata out 64, o_req_wstrb out 8.
REQ-008 SHALL have bus response ports i_resp_valid in 1, i_resp_rdata in 64.
REQ-009 SHALL have WB-side outputs o_wb_valid 1, o_rd_wen 1, o_rd_addr 5, o_rd_data 64, o_mem_read 1, o_mem_rdata 64, all registered.

Function
REQ-010 SHALL implement FSM IDLE, REQ, WAIT, DONE; o_ready=1 only in IDLE.
REQ-011 IDLE, accepted op with neither mem flag: SHALL register rd fields, go DONE; o_wb_valid=1 next cycle (latency 1).
REQ-012 IDLE, accepted load or store: SHALL latch all inputs, go REQ.
REQ-013 REQ: o_req_valid=1 with stable addr/wen/wdata/wstrb until i_req_ready=1, then WAIT; SHALL NOT change request while stalled.
REQ-014 WAIT: on i_resp_valid=1 SHALL register result and go DONE; i_resp_valid outside WAIT SHALL be ignored.
REQ-015 DONE: o_wb_valid=1 for exactly one cycle, then IDLE; one op in flight max.
REQ-016 Store: wstrb = size mask (1,3,0xF,0xFF) shifted left by addr[2:0]; wdata = i_wdata shifted left 8*addr[2:0].
REQ-017 Load: o_mem_rdata = i_resp_rdata >> 8*addr[2:0], truncated to size, sign-extended unless i_unsigned; size 3 ignores i_unsigned.
REQ-018 o_mem_read SHALL equal latched i_mem_read; store SHALL force o_rd_wen=0.
REQ-019 i_mem_read and i_mem_write both high SHALL be treated as load.
REQ-020 i_req_ready and i_resp_valid in same REQ cycle: SHALL go WAIT only; response accepted from WAIT.
REQ-021 o_wb_valid=0 outside DONE; o_rd_wen SHALL be gated by o_wb_valid.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, all outputs 0 except o_ready=1.
REQ-023 Reset mid-REQ/WAIT SHALL abandon the op; o_req_valid drops asynchronously; no WB result.

Configuration
REQ-024 With YSYX_210238_LSU_MISALIGN_CHK_EN defined: output o_misalign (1 bit) added; access not naturally aligned to size SHALL skip REQ/WAIT, go DONE with o_misalign=1, o_rd_wen=0.
REQ-025 Without the macro: no o_misalign port; addr low bits used as-is, bytes beyond lane 7 dropped.

Structure
REQ-026 Shared package SHALL hold FSM state encoding, size codes, and wstrb base masks.
REQ-027 Load extraction/extension SHALL be sub-module ysyx_210238_lsu_ldext (combinational).

Verification
REQ-028 ALU op rd_addr=5, rd_data=0x1234 -> one cycle later o_wb_valid=1, o_rd_wen=1, o_rd_data=0x1234, no bus request.
REQ-029 LB addr=0x8000_0003, signed, rdata=0x0000_0000_8000_0000 -> byte 0x80 -> o_mem_rdata=0xFFFF_FFFF_FFFF_FF80; LBU -> 0x80.
REQ-030 SH addr=0x8000_0006, wdata=0xBEEF -> o_req_addr=0x8000_0000, wstrb=0xC0, wdata=0xBEEF_0000_0000_0000, o_rd_wen=0.
REQ-031 i_req_ready low 5 cycles -> request held stable 5 cycles, o_ready=0, single WB pulse after response.
REQ-032 rst_n low during WAIT -> o_req_valid=0, o_wb_valid=0, o_ready=1 immediately; later i_resp_valid ignored.
REQ-033 Macro on, LW addr=0x8000_0002 -> o_misalign=1, no o_req_valid, o_wb_valid=1 after 1 cycle.
